imem_arbiter: RTL

Shares the single combinational read port of the instruction memory between the pipeline fetch stage and a debug/loader read port. Fetch has fixed priority. A starvation counter guarantees the debug port a grant within a bounded number of cycles. Read data from the combinational memory is registered and returned one cycle after grant, with a per-port valid pulse and a misalignment error flag. The block sits between the PC/IF stage, the debug interface and the instruction memory.

---
 rtl/imem_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the combinational instruction-memory read port
// between the fetch stage (fixed priority) and a debug/loader port.
// A saturating starvation counter forces a debug grant after STARVE_LIMIT
// denied cycles. Read data is registered and returned one cycle after grant.
module imem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_inst
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    // Port index 0 = fetch, 1 = debug.
    localparam int NP = 2;

    logic [CW-1:0]        starve_q, starve_d;
    logic                 force_dbg;
    logic                 misaligned;
    logic [NP-1:0]        gnt;
    logic [NP-1:0]        rvalid_q, rvalid_d;
    logic [NP-1:0]        err_q, err_d;
    logic [NP-1:0][31:0]  rdata_q, rdata_d;

    // Grant selection and memory port steering; no grant while in reset.
    always_comb begin
        force_dbg = dbg_req & (starve_q == LIMIT);
        gnt[1]    = ~rst & dbg_req & (force_dbg | ~if_req | if_flush);
        gnt[0]    = ~rst & if_req & ~if_flush & ~force_dbg;
        misaligned = 1'b0;
        mem_addr   = '0;
        if (gnt[1]) begin
            misaligned = |dbg_addr[1:0];
            mem_addr   = dbg_addr;
        end else if (gnt[0]) begin
            misaligned = |if_addr[1:0];
            mem_addr   = if_addr;
        end
        mem_rd_en = (gnt[0] | gnt[1]) & ~misaligned;
    end

    // Starvation counter: counts consecutive denied debug cycles, clears on
    // grant or when the request is withdrawn.
    always_comb begin
        starve_d = '0;
        if (dbg_req & ~gnt[1])
            starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end

    // Per-port response registers: capture on grant, rdata holds otherwise.
    for (genvar p = 0; p < NP; p++) begin : g_rsp
        always_comb begin
            rvalid_d[p] = gnt[p];
            err_d[p]    = gnt[p] & misaligned;
            rdata_d[p]  = rdata_q[p];
            if (gnt[p]) rdata_d[p] = misaligned ? 32'h0 : mem_inst;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rvalid_q[p] <= 1'b0;
                err_q[p]    <= 1'b0;
                rdata_q[p]  <= '0;
            end else begin
                rvalid_q[p] <= rvalid_d[p];
                err_q[p]    <= err_d[p];
                rdata_q[p]  <= rdata_d[p];
            end
        end
    end

    // A flush kills the fetch response that is in flight this cycle.
    assign if_gnt     = gnt[0];
    assign dbg_gnt    = gnt[1];
    assign if_rvalid  = rvalid_q[0] & ~if_flush;
    assign if_err     = err_q[0] & ~if_flush;
    assign if_rdata   = rdata_q[0];
    assign dbg_rvalid = rvalid_q[1];
    assign dbg_err    = err_q[1];
    assign dbg_rdata  = rdata_q[1];

endmodule
